// File: rtl/mprj_flash_arb_pkg.sv
// mprj_flash_arb_pkg: shared state encodings, register map and bit positions for the flash arbiter.
package mprj_flash_arb_pkg;
  typedef enum logic [1:0] {ST_CORE, ST_TO_MGMT, ST_MGMT, ST_TO_CORE} own_state_t;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam int CTRL_OWN_REQ = 0;
  localparam int CTRL_CS = 1;
  localparam int STAT_OVERRUN = 3;
  function automatic logic [31:0] status_word(input logic owned, busy, switching, overrun);
    return {28'd0, overrun, switching, busy, owned};
  endfunction
endpackage

// File: rtl/mprj_flash_arbiter_shifter.sv
// spi_byte_shifter: mode-0 MSB-first byte shifter; divider is latched at start so mid-transfer writes wait.
module spi_byte_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] div,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic [7:0] rx_byte
);
  logic [7:0] dv, cnt, tx, rx;
  logic [2:0] bits;
  assign mosi = tx[7];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {sck, busy, bits} <= '0;
      {dv, cnt, tx, rx, rx_byte} <= '0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      dv <= div;
      cnt <= '0;
      tx <= tx_byte;
      bits <= '0;
      sck <= 1'b0;
    end else if (busy) begin
      if (cnt != dv) cnt <= cnt + 1'b1;
      else begin
        cnt <= '0;
        sck <= ~sck;
        if (!sck) rx <= {rx[6:0], miso};
        else begin
          tx <= {tx[6:0], 1'b0};
          bits <= bits + 1'b1;
          if (bits == 3'd7) begin
            busy <= 1'b0;
            rx_byte <= rx;
          end
        end
      end
    end
  end
endmodule

// File: rtl/mprj_flash_arbiter.sv
// mprj_flash_arbiter: shares the SPI flash pads between microwatt and the management SoC,
// with Wishbone registers, a guarded ownership FSM and a byte shifter for management access.
module mprj_flash_arbiter
  import mprj_flash_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int GUARD_CYCLES = 4,
  parameter logic [7:0] DEFAULT_DIV = 8'd3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        core_flash_cs_n,
  input  logic        core_flash_clk,
  input  logic [3:0]  core_flash_sdat_o,
  input  logic [3:0]  core_flash_sdat_oe,
  output logic [3:0]  core_flash_sdat_i,
  output logic        core_hold,
  output logic        pad_flash_cs_n,
  output logic        pad_flash_clk,
  output logic [3:0]  pad_sdat_o,
  output logic [3:0]  pad_sdat_oeb,
  input  logic [3:0]  pad_sdat_i
);
  localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);
  own_state_t state;
  logic [7:0] cnt, clkdiv, rx;
  logic own_req, cs, overrun, hit, wr, start, sck, mosi, busy, core_mode, mgmt;
  logic [1:0] reg_sel;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[7:4], wbs_adr_i[1:0]};
  assign hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign reg_sel = wbs_adr_i[3:2];
  assign wr = wbs_ack_o & hit & wbs_we_i;
  assign core_mode = state == ST_CORE;
  assign mgmt = state == ST_MGMT;
  assign start = wr & (reg_sel == REG_DATA) & wbs_sel_i[0] & mgmt & ~busy;
  assign rdata = reg_sel == REG_CTRL ? {16'd0, clkdiv, 6'd0, cs, own_req} :
                 reg_sel == REG_STATUS ? status_word(mgmt, busy, ~core_mode & ~mgmt, overrun) :
                 reg_sel == REG_DATA ? {24'd0, rx} : 32'd0;
  // Acks are one-cycle pulses; the ~ack term forces a gap before the next access is acked.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      {own_req, cs, overrun} <= '0;
      clkdiv <= DEFAULT_DIV;
    end else begin
      wbs_ack_o <= hit & ~wbs_ack_o;
      if (hit && !wbs_ack_o) wbs_dat_o <= rdata;
      if (wr && reg_sel == REG_CTRL && wbs_sel_i[0]) begin
        own_req <= wbs_dat_i[CTRL_OWN_REQ];
        cs <= wbs_dat_i[CTRL_CS];
      end
      if (wr && reg_sel == REG_CTRL && wbs_sel_i[1]) clkdiv <= wbs_dat_i[15:8];
      if (wr && reg_sel == REG_STATUS && wbs_sel_i[0] && wbs_dat_i[STAT_OVERRUN]) overrun <= 1'b0;
      if (wr && reg_sel == REG_DATA && wbs_sel_i[0] && mgmt && busy) overrun <= 1'b1;
    end
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_CORE;
      cnt <= '0;
    end else begin
      case (state)
        ST_CORE: if (own_req) begin
          state <= ST_TO_MGMT;
          cnt <= '0;
        end
        ST_TO_MGMT: if (!own_req) begin
          state <= ST_TO_CORE;
          cnt <= '0;
        end else if (!core_flash_cs_n) cnt <= '0;
        else if (cnt == GUARD_LAST) begin
          state <= ST_MGMT;
          cnt <= '0;
        end else cnt <= cnt + 1'b1;
        ST_MGMT: if (!own_req && !busy && !start) begin
          state <= ST_TO_CORE;
          cnt <= '0;
        end
        ST_TO_CORE: if (own_req) begin
          state <= ST_TO_MGMT;
          cnt <= '0;
        end else if (cnt == GUARD_LAST) state <= ST_CORE;
        else cnt <= cnt + 1'b1;
        default: state <= ST_CORE;
      endcase
    end
  end
  spi_byte_shifter u_shifter (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .start(start),
    .div(clkdiv),
    .tx_byte(wbs_dat_i[7:0]),
    .miso(pad_sdat_i[1]),
    .sck(sck),
    .mosi(mosi),
    .busy(busy),
    .rx_byte(rx)
  );
  assign pad_flash_cs_n = core_mode ? core_flash_cs_n : mgmt ? ~cs : 1'b1;
  assign pad_flash_clk = core_mode ? core_flash_clk : mgmt & sck;
  assign pad_sdat_o = core_mode ? core_flash_sdat_o : {3'b0, mgmt & mosi};
  assign pad_sdat_oeb = core_mode ? ~core_flash_sdat_oe : 4'b1110;
  assign core_flash_sdat_i = core_mode ? pad_sdat_i : 4'hF;
  assign core_hold = ~core_mode;
endmodule

// File: tb/tb_mprj_flash_arbiter.sv
// tb_mprj_flash_arbiter: randomized scenario bench with an SPI slave model and byte-level expectations.
module tb_mprj_flash_arbiter;
  localparam logic [31:0] CTRL = 32'h3000_0000;
  localparam logic [31:0] STATUS = 32'h3000_0004;
  localparam logic [31:0] DATA = 32'h3000_0008;
  localparam int GUARD = 4;
  logic clk = 1'b0, rst;
  logic stb, cyc, we;
  logic [3:0] sel;
  logic [31:0] adr, wdat, rdat;
  logic ack, hold, pcs, pclk, core_cs_n, core_clk;
  logic [3:0] core_o, core_oe, core_i, pso, poeb, psi, tb_psi;
  int tests = 0, fails = 0;
  logic mon_en = 1'b0;
  int xfer_id = 0, seen_id = 0, rises = 0, falls = 0;
  logic [7:0] miso_byte = 8'h00, mosi_cap = 8'h00;
  logic prev_clk = 1'b0;

  always #5 clk = ~clk;

  mprj_flash_arbiter dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .core_flash_cs_n(core_cs_n), .core_flash_clk(core_clk), .core_flash_sdat_o(core_o),
    .core_flash_sdat_oe(core_oe), .core_flash_sdat_i(core_i), .core_hold(hold),
    .pad_flash_cs_n(pcs), .pad_flash_clk(pclk), .pad_sdat_o(pso), .pad_sdat_oeb(poeb),
    .pad_sdat_i(psi)
  );

  // SPI slave: presents miso_byte MSB first, advancing on each falling sck, captures MOSI on rising sck.
  assign psi = mon_en ? {tb_psi[3:2], miso_byte[3'(7 - falls)], tb_psi[0]} : tb_psi;
  always @(negedge clk) begin
    if (xfer_id != seen_id) begin
      seen_id = xfer_id;
      rises = 0;
      falls = 0;
      mosi_cap = 8'h00;
      prev_clk = 1'b0;
    end else if (mon_en) begin
      if (pclk && !prev_clk) begin
        mosi_cap = {mosi_cap[6:0], pso[0]};
        rises++;
      end
      if (!pclk && prev_clk) falls++;
      prev_clk = pclk;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic wb_access(input logic w, input logic [31:0] a, d, input logic [3:0] s,
                           output logic [31:0] r);
    int i;
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) break;
    end
    r = rdat;
    if (i == 8) begin
      tests++; fails++;
      $display("FAIL wb_timeout adr=%h no ack within 8 cycles", a);
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, d);
    logic [31:0] r;
    wb_access(1'b1, a, d, 4'hF, r);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_access(1'b0, a, 32'h0, 4'hF, r);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic [12:0] got, exp;
    rst = 1'b1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    core_cs_n = 1'b0; core_clk = 1'b1; core_o = 4'hA; core_oe = 4'hF; tb_psi = 4'h5;
    #1;
    tests++;
    if ({hold, ack, rdat} !== 34'h0) begin
      fails++; $display("FAIL reset_outputs got hold=%b ack=%b dat=%h exp 0/0/0", hold, ack, rdat);
    end
    tests++;
    got = {pcs, pclk, pso, poeb, core_i};
    if (got !== {1'b0, 1'b1, 4'hA, 4'h0, 4'h5}) begin
      fails++; $display("FAIL reset_mirror got=%h exp=%h", got, {1'b0, 1'b1, 4'hA, 4'h0, 4'h5});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      {core_cs_n, core_clk, core_o, core_oe, tb_psi} = 14'($urandom);
      #1;
      got = {pcs, pclk, pso, poeb, core_i};
      exp = {core_cs_n, core_clk, core_o, ~core_oe, tb_psi};
      tests++;
      if (got !== exp || hold !== 1'b0) begin
        fails++; $display("FAIL core_passthrough got=%h hold=%b exp=%h hold=0", got, hold, exp);
      end
    end
    wb_read(CTRL, r);
    tests++;
    if (r !== 32'h0000_0300) begin fails++; $display("FAIL ctrl_reset got=%h exp=00000300", r); end
    wb_read(STATUS, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL status_reset got=%h exp=0", r); end
    wb_read(32'h3000_000C, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL reg_c got=%h exp=0", r); end
  endtask

  task automatic test_wishbone;
    int acks, consec;
    logic last;
    logic [31:0] r;
    @(posedge clk);
    #1 cyc = 1; stb = 1; we = 0; adr = 32'h3000_0104; sel = 4'hF;
    acks = 0;
    repeat (6) begin @(negedge clk); if (ack) acks++; end
    tests++;
    if (acks !== 0) begin fails++; $display("FAIL miss_no_ack got=%0d acks exp=0", acks); end
    @(posedge clk);
    #1 adr = CTRL;
    acks = 0; consec = 0; last = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack) acks++;
      if (ack && last) consec++;
      last = ack;
    end
    @(posedge clk);
    #1 cyc = 0; stb = 0;
    tests++;
    if (acks !== 4 || consec !== 0) begin
      fails++; $display("FAIL held_stb_acks got=%0d consec=%0d exp=4 consec=0", acks, consec);
    end
    wb_access(1'b1, CTRL, 32'hFFFF_FFFF, 4'b0010, r);
    wb_read(CTRL, r);
    tests++;
    if (r !== 32'h0000_FF00 || hold !== 1'b0) begin
      fails++; $display("FAIL byte_select got=%h hold=%b exp=0000ff00 hold=0", r, hold);
    end
    wb_write(CTRL, 32'h0000_0300);
  endtask

  task automatic test_take_ownership;
    logic [31:0] r;
    int bad;
    core_cs_n = 1'b0;
    wb_write(CTRL, 32'h0000_0301);
    @(posedge clk);
    #1;
    bad = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!(hold && pcs && !pclk && core_i == 4'hF && poeb == 4'b1110)) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL guard_pads got=%0d bad cycles exp=0", bad); end
    core_cs_n = 1'b1;
    repeat (2) @(posedge clk);
    wb_read(STATUS, r);
    tests++;
    if (r !== 32'h4) begin fails++; $display("FAIL switching_4th got=%h exp=4", r); end
    wb_read(STATUS, r);
    tests++;
    if (r !== 32'h1 || pcs !== 1'b1) begin
      fails++; $display("FAIL owned got=%h pcs=%b exp=1 pcs=1", r, pcs);
    end
  endtask

  task automatic do_xfer(input logic [7:0] tx, rxb, input int d, input bit spec_case);
    int n;
    logic [31:0] r;
    n = 16 * (d + 1);
    miso_byte = rxb;
    xfer_id++;
    mon_en = 1'b1;
    wb_write(DATA, {24'h0, tx});
    if (spec_case) begin
      repeat (n - 2) @(posedge clk);
      wb_read(STATUS, r);
      tests++;
      if (r !== 32'h3) begin fails++; $display("FAIL busy_last_cycle got=%h exp=3", r); end
      wb_read(DATA, r);
    end else begin
      repeat (n - 1) @(posedge clk);
      wb_read(DATA, r);
    end
    tests++;
    if (r !== {24'h0, rxb}) begin fails++; $display("FAIL rx_byte div=%0d got=%h exp=%h", d, r, rxb); end
    tests++;
    if (mosi_cap !== tx || rises !== 8) begin
      fails++; $display("FAIL mosi div=%0d got=%h edges=%0d exp=%h edges=8", d, mosi_cap, rises, tx);
    end
    wb_read(STATUS, r);
    tests++;
    if (r !== 32'h1) begin fails++; $display("FAIL idle_after_xfer got=%h exp=1", r); end
    mon_en = 1'b0;
  endtask

  task automatic test_transfer;
    int d;
    wb_write(CTRL, 32'h0000_0103);
    tests++;
    if (pcs !== 1'b0) begin fails++; $display("FAIL mgmt_cs got=%b exp=0", pcs); end
    do_xfer(8'hA5, 8'h3C, 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      d = int'($urandom_range(0, 3));
      wb_write(CTRL, 32'h0000_0003 | (d << 8));
      do_xfer(8'($urandom), 8'($urandom), d, 1'b0);
    end
  endtask

  task automatic test_overrun;
    logic [7:0] tx, rxb;
    logic [31:0] r;
    tx = 8'($urandom); rxb = 8'($urandom);
    wb_write(CTRL, 32'h0000_0103);
    miso_byte = rxb;
    xfer_id++;
    mon_en = 1'b1;
    wb_write(DATA, {24'h0, tx});
    wb_write(DATA, {24'h0, ~tx});
    wb_read(STATUS, r);
    tests++;
    if (r !== 32'hB) begin fails++; $display("FAIL overrun_set got=%h exp=b", r); end
    repeat (40) @(posedge clk);
    wb_read(DATA, r);
    tests++;
    if (r !== {24'h0, rxb} || mosi_cap !== tx) begin
      fails++; $display("FAIL overrun_first_kept got=%h mosi=%h exp=%h mosi=%h", r, mosi_cap, rxb, tx);
    end
    wb_write(STATUS, 32'h8);
    wb_read(STATUS, r);
    tests++;
    if (r !== 32'h1) begin fails++; $display("FAIL overrun_clear got=%h exp=1", r); end
    mon_en = 1'b0;
  endtask

  task automatic test_release;
    logic [7:0] tx, rxb;
    logic [31:0] r;
    int g, i;
    tx = 8'($urandom); rxb = 8'($urandom);
    core_cs_n = 1'b0;
    miso_byte = rxb;
    xfer_id++;
    mon_en = 1'b1;
    wb_write(DATA, {24'h0, tx});
    wb_write(CTRL, 32'h0000_0102);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pcs) break;
    end
    tests++;
    if (i == 100 || rises !== 8 || falls !== 8 || mosi_cap !== tx || pclk !== 1'b0) begin
      fails++;
      $display("FAIL release_after_byte got edges=%0d/%0d mosi=%h exp 8/8 mosi=%h", rises, falls, mosi_cap, tx);
    end
    mon_en = 1'b0;
    g = 0;
    while (hold && g < 20) begin
      g++;
      @(negedge clk);
    end
    tests++;
    if (g !== GUARD || pcs !== core_cs_n) begin
      fails++; $display("FAIL to_core_guard got=%0d cycles pcs=%b exp=%0d pcs=%b", g, pcs, GUARD, core_cs_n);
    end
    wb_read(DATA, r);
    tests++;
    if (r !== {24'h0, rxb}) begin fails++; $display("FAIL release_rx got=%h exp=%h", r, rxb); end
    wb_write(DATA, 32'h55);
    repeat (40) @(posedge clk);
    wb_read(STATUS, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL data_in_core got=%h exp=0", r); end
  endtask

  task automatic test_guard_exact;
    int g;
    core_cs_n = 1'b1;
    wb_write(CTRL, 32'h0000_0102);
    wb_write(CTRL, 32'h0000_0103);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hold) break;
    end
    g = 0;
    while (hold && pcs && g < 20) begin
      g++;
      @(negedge clk);
    end
    tests++;
    if (g !== GUARD || hold !== 1'b1 || pcs !== 1'b0) begin
      fails++; $display("FAIL to_mgmt_guard got=%0d hold=%b pcs=%b exp=%0d 1 0", g, hold, pcs, GUARD);
    end
  endtask

  task automatic test_reset_midxfer;
    logic [31:0] r;
    logic [14:0] got, exp;
    int i;
    miso_byte = 8'($urandom);
    xfer_id++;
    mon_en = 1'b1;
    wb_write(DATA, 32'h0000_00C3);
    repeat (6) @(posedge clk);
    mon_en = 1'b0;
    {core_cs_n, core_clk, core_o, core_oe, tb_psi} = 14'($urandom) | 14'h1000;
    @(posedge clk);
    #1 cyc = 1; stb = 1; we = 0; adr = STATUS; sel = 4'hF;
    for (i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) break;
    end
    #1 rst = 1'b1;
    #1;
    got = {ack, hold, pcs, pclk, pso, poeb, core_i};
    exp = {1'b0, 1'b0, core_cs_n, core_clk, core_o, ~core_oe, tb_psi};
    tests++;
    if (i == 4 || got !== exp || rdat !== 32'h0) begin
      fails++; $display("FAIL async_reset got=%h dat=%h exp=%h dat=0", got, rdat, exp);
    end
    @(posedge clk);
    #1 cyc = 0; stb = 0;
    core_clk = 1'b0;
    #1;
    tests++;
    if (pclk !== 1'b0 || pcs !== core_cs_n || hold !== 1'b0) begin
      fails++; $display("FAIL reset_hold got clk=%b cs=%b hold=%b exp 0 %b 0", pclk, pcs, hold, core_cs_n);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    wb_read(CTRL, r);
    tests++;
    if (r !== 32'h0000_0300) begin fails++; $display("FAIL ctrl_after_reset got=%h exp=00000300", r); end
    wb_read(DATA, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL data_after_reset got=%h exp=0", r); end
  endtask

  initial begin
    test_reset;
    test_wishbone;
    test_take_ownership;
    test_transfer;
    test_overrun;
    test_release;
    test_guard_exact;
    test_reset_midxfer;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
